// File: rtl/multicycle_sequencer.sv
// Control sequencer for the multicycle RISC core: owns PC/NPC/IR/SP and runs the
// FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK/HALT state machine with memory handshakes.
module multicycle_sequencer #(
    parameter int WIDTH   = 32,
    parameter int PC_SIZE = 8,
    parameter int SP_INIT = 255,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [PC_SIZE-1:0] imem_addr,
    input  logic               imem_ready,
    input  logic [WIDTH-1:0]   imem_rdata,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [PC_SIZE-1:0] dmem_sp_addr,
    input  logic               dmem_ready,
    input  logic [WIDTH-1:0]   dmem_rdata,
    input  logic               cond_true,
    input  logic [PC_SIZE-1:0] target,
    output logic [2:0]         state,
    output logic [WIDTH-1:0]   ir,
    output logic [PC_SIZE-1:0] pc,
    output logic [PC_SIZE-1:0] npc,
    output logic [PC_SIZE-1:0] sp,
    output logic               alu_en,
    output logic               rf_we,
    output logic               halted,
    output logic [CNT_W-1:0]   retired
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    localparam logic [PC_SIZE-1:0] SP_RST = PC_SIZE'(SP_INIT);
    localparam logic [PC_SIZE-1:0] PC_ONE = {{(PC_SIZE-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]   CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end else begin
            return v + CNT_ONE;
        end
    endfunction

    // Store, push (funct2=00) and call (funct2=10) write to data memory.
    function automatic logic is_write(input logic [WIDTH-1:0] i);
        if (i[31:29] == 3'b010) begin
            return i[0];
        end else if (i[31:29] == 3'b100) begin
            return ~i[27];
        end else begin
            return 1'b0;
        end
    endfunction

    state_t               state_r, state_nx_s;
    logic [PC_SIZE-1:0]   pc_r, pc_nx_s, npc_r, npc_nx_s, sp_r, sp_nx_s;
    logic [WIDTH-1:0]     ir_r, ir_nx_s;
    logic [CNT_W-1:0]     retired_r;
    logic                 retire_s;
    logic                 imem_req_r, dmem_req_r, dmem_we_r, alu_en_r, rf_we_r, halted_r;
    logic [PC_SIZE-1:0]   dmem_sp_addr_r;
    logic                 fetch_ok_s, mem_ok_s;
    logic [2:0]           opcode_s;
    logic [1:0]           funct2_s;
    logic [PC_SIZE+15:0]  sp_ext_s;
    logic [PC_SIZE-1:0]   sp_off_s;
    logic                 unused_s;

    assign opcode_s   = ir_r[31:29];
    assign funct2_s   = ir_r[28:27];
    assign fetch_ok_s = imem_req_r & imem_ready;
    assign mem_ok_s   = dmem_req_r & dmem_ready;
    assign sp_ext_s   = {{PC_SIZE{ir_r[20]}}, ir_r[20:5]};
    assign sp_off_s   = sp_ext_s[PC_SIZE-1:0];
    assign unused_s   = ^{dmem_rdata[WIDTH-1:PC_SIZE], sp_ext_s[PC_SIZE+15:PC_SIZE]};

    // Next-state and architectural-register update logic.
    always_comb begin
        state_nx_s = state_r;
        pc_nx_s    = pc_r;
        npc_nx_s   = npc_r;
        ir_nx_s    = ir_r;
        sp_nx_s    = sp_r;
        retire_s   = 1'b0;
        case (state_r)
            S_FETCH: begin
                if (fetch_ok_s) begin
                    ir_nx_s    = imem_rdata;
                    npc_nx_s   = pc_r + PC_ONE;
                    state_nx_s = S_DECODE;
                end else begin
                    state_nx_s = S_FETCH;
                end
            end
            S_DECODE: state_nx_s = S_EXECUTE;
            S_EXECUTE: begin
                case (opcode_s)
                    3'b000, 3'b001, 3'b101: state_nx_s = S_WRITEBACK;
                    3'b111: begin
                        sp_nx_s    = sp_r + sp_off_s;
                        state_nx_s = S_WRITEBACK;
                    end
                    3'b010, 3'b100: state_nx_s = S_MEMORY;
                    3'b011: begin
                        if ((funct2_s == 2'b00) || cond_true) begin
                            pc_nx_s = target;
                        end else begin
                            pc_nx_s = npc_r;
                        end
                        retire_s   = 1'b1;
                        state_nx_s = S_FETCH;
                    end
                    3'b110: begin
                        pc_nx_s  = npc_r;
                        retire_s = 1'b1;
                        if (ir_r[28]) begin
                            state_nx_s = S_HALT;
                        end else begin
                            state_nx_s = S_FETCH;
                        end
                    end
                    default: state_nx_s = S_FETCH;
                endcase
            end
            S_MEMORY: begin
                if (!mem_ok_s) begin
                    state_nx_s = S_MEMORY;
                end else if (opcode_s == 3'b100) begin
                    case (funct2_s)
                        2'b00: begin
                            sp_nx_s    = sp_r - PC_ONE;
                            pc_nx_s    = npc_r;
                            retire_s   = 1'b1;
                            state_nx_s = S_FETCH;
                        end
                        2'b01: begin
                            sp_nx_s    = sp_r + PC_ONE;
                            state_nx_s = S_WRITEBACK;
                        end
                        2'b10: begin
                            sp_nx_s    = sp_r - PC_ONE;
                            pc_nx_s    = target;
                            retire_s   = 1'b1;
                            state_nx_s = S_FETCH;
                        end
                        default: begin
                            sp_nx_s    = sp_r + PC_ONE;
                            pc_nx_s    = dmem_rdata[PC_SIZE-1:0];
                            retire_s   = 1'b1;
                            state_nx_s = S_FETCH;
                        end
                    endcase
                end else if (ir_r[0]) begin
                    pc_nx_s    = npc_r;
                    retire_s   = 1'b1;
                    state_nx_s = S_FETCH;
                end else begin
                    state_nx_s = S_WRITEBACK;
                end
            end
            S_WRITEBACK: begin
                pc_nx_s    = npc_r;
                retire_s   = 1'b1;
                state_nx_s = S_FETCH;
            end
            S_HALT:  state_nx_s = S_HALT;
            default: state_nx_s = S_FETCH;
        endcase
    end

    // State, architectural registers and next-state-decoded output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r        <= S_FETCH;
            pc_r           <= {PC_SIZE{1'b0}};
            npc_r          <= {PC_SIZE{1'b0}};
            ir_r           <= {WIDTH{1'b0}};
            sp_r           <= SP_RST;
            retired_r      <= {CNT_W{1'b0}};
            imem_req_r     <= 1'b0;
            dmem_req_r     <= 1'b0;
            dmem_we_r      <= 1'b0;
            dmem_sp_addr_r <= SP_RST;
            alu_en_r       <= 1'b0;
            rf_we_r        <= 1'b0;
            halted_r       <= 1'b0;
        end else begin
            state_r        <= state_nx_s;
            pc_r           <= pc_nx_s;
            npc_r          <= npc_nx_s;
            ir_r           <= ir_nx_s;
            sp_r           <= sp_nx_s;
            retired_r      <= retire_s ? sat_inc(retired_r) : retired_r;
            imem_req_r     <= (state_nx_s == S_FETCH);
            dmem_req_r     <= (state_nx_s == S_MEMORY);
            dmem_we_r      <= (state_nx_s == S_MEMORY) && is_write(ir_nx_s);
            // Pop/ret (funct2[0]=1) read the slot above SP; push/call write at SP.
            dmem_sp_addr_r <= ir_nx_s[27] ? (sp_nx_s + PC_ONE) : sp_nx_s;
            alu_en_r       <= (state_nx_s == S_EXECUTE);
            rf_we_r        <= (state_nx_s == S_WRITEBACK);
            halted_r       <= (state_nx_s == S_HALT);
        end
    end

    assign imem_req     = imem_req_r;
    assign imem_addr    = pc_r;
    assign dmem_req     = dmem_req_r;
    assign dmem_we      = dmem_we_r;
    assign dmem_sp_addr = dmem_sp_addr_r;
    assign state        = state_r;
    assign ir           = ir_r;
    assign pc           = pc_r;
    assign npc          = npc_r;
    assign sp           = sp_r;
    assign alu_en       = alu_en_r;
    assign rf_we        = rf_we_r;
    assign halted       = halted_r;
    assign retired      = retired_r;

endmodule
